// File: rtl/spi_slave_pkg.sv
// Shared constants and types for the SPI target engine and its slot wrapper.
package spi_slave_pkg;

  localparam logic [1:0] SPI_S_RX_STAT = 2'd0;
  localparam logic [1:0] SPI_S_TX      = 2'd1;
  localparam logic [1:0] SPI_S_CTRL    = 2'd2;

  localparam int ST_RX_VALID = 8;
  localparam int ST_TX_EMPTY = 9;
  localparam int ST_OVERRUN  = 10;
  localparam int ST_UNDERRUN = 11;
  localparam int ST_BUSY     = 12;

  typedef enum logic {IDLE, ACTIVE} spi_s_state_t;

endpackage

// File: rtl/spi_slave.sv
// SPI target engine: pin synchronisers, sclk edge detect, IDLE/ACTIVE FSM and shift registers.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  input  logic       spi_ss_n,
  input  logic [7:0] tx_byte,
  input  logic       tx_avail,
  input  logic       cpol,
  input  logic       cpha,
  output logic       spi_miso,
  output logic       tx_load_tick,
  output logic [7:0] rx_byte,
  output logic       rx_done_tick,
  output logic       busy
);

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   ss_prev_q, ss_prev_d;
  spi_s_state_t           state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             tx_sr_q, tx_sr_d;
  logic [7:0]             rx_sr_q, rx_sr_d;

  logic sclk_s, mosi_s, ss_s;
  logic lead_edge, trail_edge, sample_edge, shift_edge, ss_fall, ss_rise;
  logic [7:0] tx_next;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign ss_s   = ss_sync_q[SYNC_STAGES-1];

  assign lead_edge   = (sclk_prev_q == cpol) && (sclk_s != cpol);
  assign trail_edge  = (sclk_prev_q != cpol) && (sclk_s == cpol);
  assign sample_edge = cpha ? trail_edge : lead_edge;
  assign shift_edge  = cpha ? lead_edge : trail_edge;
  assign ss_fall     = ss_prev_q && !ss_s;
  assign ss_rise     = !ss_prev_q && ss_s;

  assign tx_next  = tx_avail ? tx_byte : 8'hFF;
  assign rx_byte  = {rx_sr_q[6:0], mosi_s};
  assign busy     = (state_q == ACTIVE);
  assign spi_miso = busy ? tx_sr_q[7] : 1'b1;

  always_comb begin
    sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
    mosi_sync_d  = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    ss_sync_d    = {ss_sync_q[SYNC_STAGES-2:0], spi_ss_n};
    sclk_prev_d  = sclk_s;
    ss_prev_d    = ss_s;
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    tx_sr_d      = tx_sr_q;
    rx_sr_d      = rx_sr_q;
    tx_load_tick = 1'b0;
    rx_done_tick = 1'b0;

    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d   = ACTIVE;
          bit_cnt_d = 3'd0;
          if (!cpha) begin
            tx_sr_d      = tx_next;
            tx_load_tick = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (sample_edge) begin
          rx_sr_d   = rx_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) rx_done_tick = 1'b1;
        end
        // bit_cnt == 0 on a shift edge means a byte boundary in both phases
        if (shift_edge) begin
          if (bit_cnt_q == 3'd0) begin
            tx_sr_d      = tx_next;
            tx_load_tick = 1'b1;
          end else begin
            tx_sr_d = {tx_sr_q[6:0], 1'b0};
          end
        end
        if (ss_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      ss_sync_q   <= '1;
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      tx_sr_q     <= 8'h00;
      rx_sr_q     <= 8'h00;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      ss_sync_q   <= ss_sync_d;
      sclk_prev_q <= sclk_prev_d;
      ss_prev_q   <= ss_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
    end
  end

endmodule

// File: rtl/spi_slave_core.sv
// Slot-bus wrapper for the SPI target: register decode, tx_hold, rx_data and sticky status flags.
module spi_slave_core
  import spi_slave_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  input  logic        spi_sclk,
  input  logic        spi_mosi,
  input  logic        spi_ss_n,
  output logic        spi_miso,
  output logic        spi_miso_en
);

  logic       cpol_q, cpol_d;
  logic       cpha_q, cpha_d;
  logic [7:0] tx_hold_q, tx_hold_d;
  logic       tx_empty_q, tx_empty_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       overrun_q, overrun_d;
  logic       underrun_q, underrun_d;

  logic       wr_en, tx_load_tick, rx_done_tick, busy;
  logic [7:0] rx_byte;
  logic       unused_ok;

  assign wr_en     = cs & write;
  assign unused_ok = ^{read, addr[4:2], wr_data[31:8]};

  spi_slave #(.SYNC_STAGES(SYNC_STAGES)) u_spi_slave (
    .clk          (clk),
    .reset        (reset),
    .spi_sclk     (spi_sclk),
    .spi_mosi     (spi_mosi),
    .spi_ss_n     (spi_ss_n),
    .tx_byte      (tx_hold_q),
    .tx_avail     (!tx_empty_q),
    .cpol         (cpol_q),
    .cpha         (cpha_q),
    .spi_miso     (spi_miso),
    .tx_load_tick (tx_load_tick),
    .rx_byte      (rx_byte),
    .rx_done_tick (rx_done_tick),
    .busy         (busy)
  );

  assign spi_miso_en = busy;

  always_comb begin
    rd_data              = 32'h0;
    rd_data[7:0]         = rx_data_q;
    rd_data[ST_RX_VALID] = rx_valid_q;
    rd_data[ST_TX_EMPTY] = tx_empty_q;
    rd_data[ST_OVERRUN]  = overrun_q;
    rd_data[ST_UNDERRUN] = underrun_q;
    rd_data[ST_BUSY]     = busy;
  end

  // Order matters: engine events set flags over a clear, but a tx_hold write beats a load.
  always_comb begin
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    tx_hold_d  = tx_hold_q;
    tx_empty_d = tx_empty_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;
    underrun_d = underrun_q;

    if (wr_en && addr[1:0] == SPI_S_RX_STAT) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
      underrun_d = 1'b0;
    end
    if (wr_en && addr[1:0] == SPI_S_CTRL) begin
      cpol_d = wr_data[0];
      cpha_d = wr_data[1];
    end
    if (rx_done_tick) begin
      rx_data_d  = rx_byte;
      rx_valid_d = 1'b1;
      if (rx_valid_q) overrun_d = 1'b1;
    end
    if (tx_load_tick) begin
      tx_empty_d = 1'b1;
      if (tx_empty_q) underrun_d = 1'b1;
    end
    if (wr_en && addr[1:0] == SPI_S_TX) begin
      tx_hold_d  = wr_data[7:0];
      tx_empty_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      tx_hold_q  <= 8'h00;
      tx_empty_q <= 1'b1;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      tx_hold_q  <= tx_hold_d;
      tx_empty_q <= tx_empty_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench for spi_slave_core: bench-side SPI master with a vector table plus hand-written corner sequences.
module tb_spi_slave_core;

  localparam int H = 8;  // sclk half period in clk cycles

  logic        clk = 1'b0;
  logic        reset;
  logic        cs, read, write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        spi_sclk, spi_mosi, spi_ss_n;
  logic        spi_miso, spi_miso_en;

  logic        cpol_m, cpha_m;
  int          total = 0;
  int          bad = 0;

  spi_slave_core #(.SYNC_STAGES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .cs          (cs),
    .read        (read),
    .write       (write),
    .addr        (addr),
    .wr_data     (wr_data),
    .rd_data     (rd_data),
    .spi_sclk    (spi_sclk),
    .spi_mosi    (spi_mosi),
    .spi_ss_n    (spi_ss_n),
    .spi_miso    (spi_miso),
    .spi_miso_en (spi_miso_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cpol;
    logic        cpha;
    logic [7:0]  tx;
    logic [7:0]  mosi;
    logic [7:0]  exp_rx;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[6];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    cs = 1'b1; write = 1'b1; addr = {3'b0, a}; wr_data = d;
    tick(1);
    cs = 1'b0; write = 1'b0; addr = 5'd0; wr_data = 32'h0;
  endtask

  task automatic set_mode(input logic pol, input logic pha);
    reg_write(2'd2, {30'b0, pha, pol});
    cpol_m = pol; cpha_m = pha;
    spi_sclk = pol;
    tick(4);
  endtask

  // One byte (or nbits of it) MSB first; optional clear-write landing on the 8th sample cycle.
  task automatic xfer(input logic [7:0] dout, input int nbits, input bit clr_last,
                      output logic [7:0] din);
    din = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!cpha_m) begin
        spi_mosi = dout[i];
        tick(H);
        spi_sclk = ~cpol_m;
        din = {din[6:0], spi_miso};
        if (clr_last && i == 0) begin
          tick(2);
          cs = 1'b1; write = 1'b1; addr = 5'd0; wr_data = 32'h0;
          tick(1);
          cs = 1'b0; write = 1'b0;
          check("clr_vs_sample_mid", rd_data, 32'h0000_17E1);
          tick(H - 3);
        end else begin
          tick(H);
        end
        spi_sclk = cpol_m;
      end else begin
        tick(H);
        spi_sclk = ~cpol_m;
        spi_mosi = dout[i];
        tick(H);
        spi_sclk = cpol_m;
        din = {din[6:0], spi_miso};
      end
    end
  endtask

  task automatic frame_start();
    spi_ss_n = 1'b0;
  endtask

  task automatic frame_end();
    tick(H);
    spi_ss_n = 1'b1;
    tick(H);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rx0, rx1;

    vecs[0] = '{cpol: 1'b0, cpha: 1'b0, tx: 8'hA5, mosi: 8'h3C, exp_rx: 8'hA5, exp_rd: 32'h0000_0B3C};
    vecs[1] = '{cpol: 1'b0, cpha: 1'b1, tx: 8'h5A, mosi: 8'hC3, exp_rx: 8'h5A, exp_rd: 32'h0000_03C3};
    vecs[2] = '{cpol: 1'b1, cpha: 1'b0, tx: 8'h5A, mosi: 8'hC3, exp_rx: 8'h5A, exp_rd: 32'h0000_0BC3};
    vecs[3] = '{cpol: 1'b1, cpha: 1'b1, tx: 8'h5A, mosi: 8'hC3, exp_rx: 8'h5A, exp_rd: 32'h0000_03C3};
    vecs[4] = '{cpol: 1'b0, cpha: 1'b0, tx: 8'h81, mosi: 8'h7E, exp_rx: 8'h81, exp_rd: 32'h0000_0B7E};
    vecs[5] = '{cpol: 1'b1, cpha: 1'b1, tx: 8'h00, mosi: 8'hFF, exp_rx: 8'h00, exp_rd: 32'h0000_03FF};

    reset = 1'b1; cs = 1'b0; read = 1'b0; write = 1'b0; addr = 5'd0; wr_data = 32'h0;
    spi_sclk = 1'b0; spi_mosi = 1'b0; spi_ss_n = 1'b1;
    cpol_m = 1'b0; cpha_m = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(1);
    check("reset_rd_data", rd_data, 32'h0000_0200);
    check("reset_miso", {31'b0, spi_miso}, 32'h1);
    check("reset_miso_en", {31'b0, spi_miso_en}, 32'h0);

    // single-byte frames in every mode (mode 0/2 end with a refill load, hence underrun)
    foreach (vecs[k]) begin
      set_mode(vecs[k].cpol, vecs[k].cpha);
      reg_write(2'd0, 32'h0);
      reg_write(2'd1, {24'h0, vecs[k].tx});
      frame_start();
      xfer(vecs[k].mosi, 8, 1'b0, rx0);
      frame_end();
      check($sformatf("vec%0d_master_rx", k), {24'h0, rx0}, {24'h0, vecs[k].exp_rx});
      check($sformatf("vec%0d_rd_data", k), rd_data, vecs[k].exp_rd);
    end

    // back-to-back bytes in mode 1 with tx_hold written once
    set_mode(1'b0, 1'b1);
    reg_write(2'd0, 32'h0);
    reg_write(2'd1, 32'h11);
    frame_start();
    xfer(8'h22, 8, 1'b0, rx0);
    xfer(8'h33, 8, 1'b0, rx1);
    frame_end();
    check("b2b_rx0", {24'h0, rx0}, 32'h11);
    check("b2b_rx1", {24'h0, rx1}, 32'hFF);
    check("b2b_rd_data", rd_data, 32'h0000_0F33);

    // partial frame aborted after 4 bits, then a full frame
    set_mode(1'b0, 1'b0);
    reg_write(2'd0, 32'h0);
    reg_write(2'd1, 32'h96);
    frame_start();
    xfer(8'hF0, 4, 1'b0, rx0);
    tick(H);
    check("partial_busy_rd", rd_data, 32'h0000_1233);
    check("partial_miso_en", {31'b0, spi_miso_en}, 32'h1);
    spi_ss_n = 1'b1;
    tick(H);
    check("partial_after_rd", rd_data, 32'h0000_0233);
    check("partial_after_miso_en", {31'b0, spi_miso_en}, 32'h0);
    check("partial_after_miso", {31'b0, spi_miso}, 32'h1);
    reg_write(2'd1, 32'h69);
    frame_start();
    xfer(8'hA7, 8, 1'b0, rx0);
    frame_end();
    check("resync_rx", {24'h0, rx0}, 32'h69);
    check("resync_rd_data", rd_data, 32'h0000_0BA7);

    // clear-write in the same cycle as the 8th sample: rx_valid and overrun still set
    reg_write(2'd1, 32'h5C);
    frame_start();
    xfer(8'hE1, 8, 1'b1, rx0);
    frame_end();
    check("clr_vs_sample_rx", {24'h0, rx0}, 32'h5C);
    check("clr_vs_sample_end", rd_data, 32'h0000_0FE1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
